// File: rtl/mlp_layer_sequencer.sv
// rtl/mlp_layer_sequencer.sv - frame sequencer driving a chain of fc_layer stages
// Each layer walks EMPTY -> FULL -> ARMED -> RUN; starts are gated by downstream space.
module mlp_layer_sequencer #(
  parameter int num_layers    = 5,
  parameter int start_timeout = 15,
  parameter int cnt_width     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_frame_valid,
  output logic                          o_frame_ready,
  input  logic [num_layers-1:0]         i_layer_busy,
  output logic [num_layers-1:0]         o_layer_start,
  output logic                          o_result_valid,
  input  logic                          i_result_ready,
  output logic                          o_error,
  output logic [$clog2(num_layers)-1:0] o_err_layer,
  output logic [cnt_width-1:0]          o_frames_done
);

  localparam int EW = $clog2(num_layers);
  localparam int TW = $clog2(start_timeout + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(start_timeout - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  logic [num_layers-1:0][1:0]    state_q, state_d;
  logic [num_layers-1:0][TW-1:0] tmr_q, tmr_d;
  logic                          result_valid_q, result_valid_d;
  logic                          error_q, error_d;
  logic [EW-1:0]                 err_layer_q, err_layer_d;
  logic [cnt_width-1:0]          frames_done_q, frames_done_d;

  logic [num_layers-1:0] empty_v;
  logic [num_layers-1:0] full_v;
  logic [num_layers-1:0] done_v;
  logic [num_layers-1:0] free_v;
  logic [num_layers-1:0] fire_v;
  logic [num_layers-1:0] fill_v;
  logic                  accept;
  logic                  err_found;

  always_comb begin
    empty_v = '0;
    full_v  = '0;
    done_v  = '0;
    for (int k = 0; k < num_layers; k++) begin
      empty_v[k] = (state_q[k] == ST_EMPTY);
      full_v[k]  = (state_q[k] == ST_FULL);
      done_v[k]  = (state_q[k] == ST_RUN) && !i_layer_busy[k];
    end
  end

  // A layer may start only if the next stage (or the result slot) is free,
  // judged on registered state so a completing neighbour frees it a cycle later.
  assign free_v = {!result_valid_q, empty_v[num_layers-1:1]};
  assign fire_v = full_v & free_v & {num_layers{!error_q}};

  assign o_frame_ready = empty_v[0] && !error_q;
  assign accept        = i_frame_valid && o_frame_ready;
  assign fill_v        = {done_v[num_layers-2:0], accept};

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    error_d     = error_q;
    err_layer_d = err_layer_q;
    err_found   = error_q;
    for (int k = 0; k < num_layers; k++) begin
      case (state_q[k])
        ST_EMPTY: begin
          if (fill_v[k]) state_d[k] = ST_FULL;
        end
        ST_FULL: begin
          if (fire_v[k]) begin
            state_d[k] = ST_ARMED;
            tmr_d[k]   = '0;
          end
        end
        ST_ARMED: begin
          if (i_layer_busy[k]) begin
            state_d[k] = ST_RUN;
          end else if (tmr_q[k] == TMO_LAST) begin
            // Ascending scan: the lowest timed-out index wins the latch.
            state_d[k] = ST_FULL;
            if (!err_found) begin
              error_d     = 1'b1;
              err_layer_d = EW'(k);
              err_found   = 1'b1;
            end
          end else begin
            tmr_d[k] = tmr_q[k] + TMR_ONE;
          end
        end
        default: begin
          if (!i_layer_busy[k]) state_d[k] = ST_EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    result_valid_d = result_valid_q;
    frames_done_d  = frames_done_q;
    if (result_valid_q && i_result_ready) begin
      result_valid_d = 1'b0;
      frames_done_d  = frames_done_q + CNT_ONE;
    end
    if (done_v[num_layers-1]) result_valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= '0;
      tmr_q          <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      err_layer_q    <= '0;
      frames_done_q  <= '0;
    end else begin
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
      err_layer_q    <= err_layer_d;
      frames_done_q  <= frames_done_d;
    end
  end

  assign o_layer_start  = fire_v;
  assign o_result_valid = result_valid_q;
  assign o_error        = error_q;
  assign o_err_layer    = err_layer_q;
  assign o_frames_done  = frames_done_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// tb/tb_mlp_layer_sequencer.sv - self-checking bench for mlp_layer_sequencer
// Emulated fc_layers plus a cycle reference model; scenario table and hand sequences.
module tb_mlp_layer_sequencer;

  localparam int N  = 5;
  localparam int TO = 15;
  localparam int CW = 4;
  localparam int S_EMPTY = 0;
  localparam int S_FULL  = 1;
  localparam int S_ARMED = 2;
  localparam int S_RUN   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_frame_valid = 1'b0;
  logic          o_frame_ready;
  logic [N-1:0]  i_layer_busy = '0;
  logic [N-1:0]  o_layer_start;
  logic          o_result_valid;
  logic          i_result_ready = 1'b0;
  logic          o_error;
  logic [2:0]    o_err_layer;
  logic [CW-1:0] o_frames_done;

  always #5 clk = ~clk;

  mlp_layer_sequencer #(.num_layers(N), .start_timeout(TO), .cnt_width(CW)) dut (
    .clk(clk), .rst(rst),
    .i_frame_valid(i_frame_valid), .o_frame_ready(o_frame_ready),
    .i_layer_busy(i_layer_busy), .o_layer_start(o_layer_start),
    .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
    .o_error(o_error), .o_err_layer(o_err_layer), .o_frames_done(o_frames_done)
  );

  typedef struct {
    int n_frames;
    int dly;
    int ln;
    int never_k;
    int ready_delay;
    bit rnd;
    int cycles;
    int exp_done;
    bit exp_err;
    int exp_errl;
  } vec_t;

  vec_t vecs[7];

  int n_chk = 0;
  int n_fail = 0;
  int st[N], arm_cyc[N], ew[N], er[N], start_cnt[N];
  bit m_rv, m_err;
  int m_errl, m_done, cyc;
  int dly, ln, never_k, frames_left;
  bit rnd, rdy_en;
  logic [N-1:0] glitch = '0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      st[k] = S_EMPTY; arm_cyc[k] = 0; ew[k] = 0; er[k] = 0; start_cnt[k] = 0;
    end
    m_rv = 0; m_err = 0; m_errl = 0; m_done = 0;
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b0;
    i_frame_valid = 1'b0; i_result_ready = 1'b0; i_layer_busy = '0; glitch = '0;
    #1;
    check("rst_start", int'(o_layer_start), 0);
    check("rst_rvalid", int'(o_result_valid), 0);
    check("rst_error", int'(o_error), 0);
    check("rst_errl", int'(o_err_layer), 0);
    check("rst_done", int'(o_frames_done), 0);
    check("rst_fready", int'(o_frame_ready), 1);
    model_reset();
    frames_left = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step();
    logic [N-1:0] b, eb, fire;
    bit frdy, acc, free, new_err;
    bit dn[N];
    int ns[N];
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      eb[k] = (ew[k] == 0 && er[k] > 0);
    end
    b = eb | glitch;
    i_layer_busy = b;
    i_frame_valid = (frames_left > 0);
    i_result_ready = rnd ? 1'($urandom_range(0, 1)) : rdy_en;
    #1;
    frdy = (st[0] == S_EMPTY) && !m_err;
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) free = !m_rv;
      else free = (st[k+1] == S_EMPTY);
      fire[k] = (st[k] == S_FULL) && !m_err && free;
    end
    check("start", int'(o_layer_start), int'(fire));
    check("frame_ready", int'(o_frame_ready), int'(frdy));
    check("result_valid", int'(o_result_valid), int'(m_rv));
    check("error", int'(o_error), int'(m_err));
    check("err_layer", int'(o_err_layer), m_errl);
    check("frames_done", int'(o_frames_done), m_done);
    for (int k = 0; k < N; k++) start_cnt[k] += int'(o_layer_start[k]);
    acc = i_frame_valid && frdy;
    if (acc) frames_left--;

    for (int k = 0; k < N; k++) dn[k] = (st[k] == S_RUN) && !b[k];
    new_err = m_err;
    for (int k = 0; k < N; k++) begin
      ns[k] = st[k];
      case (st[k])
        S_EMPTY: begin
          if (k == 0) begin
            if (acc) ns[k] = S_FULL;
          end else if (dn[k-1]) ns[k] = S_FULL;
        end
        S_FULL: if (fire[k]) begin ns[k] = S_ARMED; arm_cyc[k] = cyc; end
        S_ARMED: begin
          if (b[k]) ns[k] = S_RUN;
          else if (cyc - arm_cyc[k] >= TO) begin
            ns[k] = S_FULL;
            if (!new_err) begin new_err = 1; m_errl = k; end
          end
        end
        default: if (!b[k]) ns[k] = S_EMPTY;
      endcase
    end
    m_err = new_err;
    if (m_rv && i_result_ready) begin
      m_rv = 0;
      m_done = (m_done + 1) % (1 << CW);
    end
    if (dn[N-1]) m_rv = 1;
    for (int k = 0; k < N; k++) begin
      st[k] = ns[k];
      if (ew[k] > 0) ew[k]--;
      else if (er[k] > 0) er[k]--;
      if (fire[k] && k != never_k) begin
        ew[k] = rnd ? int'($urandom_range(0, 4)) : dly;
        er[k] = rnd ? int'($urandom_range(1, 6)) : ln;
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    do_reset();
    dly = v.dly; ln = v.ln; never_k = v.never_k; rnd = v.rnd;
    frames_left = v.n_frames;
    rdy_en = (v.ready_delay == 0);
    for (int i = 0; i < v.cycles; i++) begin
      if (i == v.ready_delay) rdy_en = 1;
      step();
    end
    check($sformatf("vec%0d_done", idx), int'(o_frames_done), v.exp_done);
    check($sformatf("vec%0d_error", idx), int'(o_error), int'(v.exp_err));
    check($sformatf("vec%0d_errl", idx), int'(o_err_layer), v.exp_errl);
    if (!v.exp_err) begin
      for (int k = 0; k < N; k++)
        check($sformatf("vec%0d_starts%0d", idx, k), start_cnt[k], v.n_frames);
    end else begin
      check($sformatf("vec%0d_fready", idx), int'(o_frame_ready), 0);
    end
  endtask

  initial begin
    bit reached;
    cyc = 0; rnd = 0; never_k = -1; dly = 2; ln = 10; rdy_en = 1;
    // n_frames dly ln never ready_delay rnd cycles exp_done exp_err exp_errl
    vecs[0] = '{1, 2, 10, -1, 0,   0, 400, 1, 0, 0};
    vecs[1] = '{2, 2, 10, -1, 150, 0, 400, 2, 0, 0};
    vecs[2] = '{3, 0, 1,  -1, 0,   0, 300, 3, 0, 0};
    vecs[3] = '{2, 2, 5,  2,  0,   0, 300, 0, 1, 2};
    vecs[4] = '{6, 0, 1,  -1, 0,   1, 600, 6, 0, 0};
    vecs[5] = '{15, 0, 1, -1, 0,   0, 400, 15, 0, 0};
    vecs[6] = '{16, 0, 1, -1, 0,   0, 400, 0, 0, 0};

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Busy glitch on an EMPTY layer must not move it or start anything.
    do_reset();
    rnd = 0; never_k = -1; dly = 1; ln = 3; rdy_en = 1;
    glitch = 5'b00010;
    repeat (3) step();
    glitch = '0;
    step();
    check("glitch_start", int'(o_layer_start), 0);
    check("glitch_fready", int'(o_frame_ready), 1);
    frames_left = 1;
    repeat (150) step();
    check("glitch_done", int'(o_frames_done), 1);

    // Reset while layers 1 and 3 are running, then a clean frame.
    do_reset();
    dly = 1; ln = 8; frames_left = 4; rdy_en = 1;
    reached = 0;
    for (int i = 0; i < 400 && !reached; i++) begin
      step();
      if (st[1] == S_RUN && st[3] == S_RUN) reached = 1;
    end
    check("midrun_reached", int'(reached), 1);
    do_reset();
    frames_left = 1;
    repeat (150) step();
    check("post_reset_done", int'(o_frames_done), 1);
    for (int k = 0; k < N; k++)
      check($sformatf("post_reset_starts%0d", k), start_cnt[k], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
